// File: rtl/fifo_rd_stream.sv
// Read-side drain for the async FIFO: pops words in the read clock domain and
// presents them on a valid/ready stream through a 2-entry elastic buffer.
module fifo_rd_stream #(
    parameter int DSIZE = 8
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic [DSIZE-1:0] rdata,
    input  logic             rempty,
    output logic             rinc,
    input  logic             rd_en,
    output logic [DSIZE-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [1:0]       occ,
    output logic [15:0]      rd_cnt
);

    // Encoding doubles as the occupancy count, so occ is the state itself.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_e;

    state_e           state_q;
    logic [DSIZE-1:0] head_q;
    logic [DSIZE-1:0] tail_q;
    logic [15:0]      rd_cnt_q;
    logic [15:0]      rd_cnt_d;
    logic             push;
    logic             pop;

    // Stream handshake: a word transfers on every rclk edge where m_valid and
    // m_ready are both high; m_valid never depends on m_ready, and m_data and
    // m_valid hold steady while m_valid=1 and m_ready=0.
    // The pop strobe only looks at our own state, never at m_ready.
    assign rinc     = rrst_n & rd_en & ~rempty & (state_q != S_TWO);
    assign push     = rinc;
    assign pop      = m_valid & m_ready;
    assign rd_cnt_d = rd_cnt_q + 16'd1;

    assign m_valid = (state_q != S_EMPTY);
    assign m_data  = head_q;
    assign occ     = state_q;
    assign rd_cnt  = rd_cnt_q;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_q  <= S_EMPTY;
            head_q   <= '0;
            tail_q   <= '0;
            rd_cnt_q <= '0;
        end else begin
            if (pop) begin
                rd_cnt_q <= rd_cnt_d;
            end
            case (state_q)
                S_EMPTY: begin
                    if (push) begin
                        head_q  <= rdata;
                        state_q <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (push && pop) begin
                        head_q <= rdata;
                    end else if (push) begin
                        tail_q  <= rdata;
                        state_q <= S_TWO;
                    end else if (pop) begin
                        state_q <= S_EMPTY;
                    end
                end
                S_TWO: begin
                    if (pop) begin
                        head_q  <= tail_q;
                        state_q <= S_ONE;
                    end
                end
                default: state_q <= S_EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: a pointer-based FIFO model feeds rdata/rempty,
// directed scenarios drive it, and a monitor checks stream order from exp_q.
module tb_fifo_rd_stream;

    logic        rclk;
    logic        rrst_n;
    logic [7:0]  rdata;
    logic        rempty;
    logic        rinc;
    logic        rd_en;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready;
    logic [1:0]  occ;
    logic [15:0] rd_cnt;

    int total;
    int bad;

    logic [7:0] exp_q[$];
    logic [7:0] mem [0:1023];
    int         wr_ptr;
    int         rd_ptr;

    fifo_rd_stream #(.DSIZE(8)) dut (
        .rclk   (rclk),
        .rrst_n (rrst_n),
        .rdata  (rdata),
        .rempty (rempty),
        .rinc   (rinc),
        .rd_en  (rd_en),
        .m_data (m_data),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .occ    (occ),
        .rd_cnt (rd_cnt)
    );

    // clock / reset
    initial begin
        rclk = 1'b0;
        forever #5 rclk = ~rclk;
    end

    // FIFO model: head word is mem[rd_ptr], pops on rinc at the clock edge
    assign rdata  = mem[rd_ptr % 1024];
    assign rempty = (rd_ptr == wr_ptr);

    always @(posedge rclk) begin
        if (rinc) rd_ptr <= rd_ptr + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // driver tasks
    task automatic drive_edge();
        @(posedge rclk);
        #1;
    endtask

    task automatic push_word(input logic [7:0] w);
        mem[wr_ptr % 1024] = w;
        wr_ptr = wr_ptr + 1;
        exp_q.push_back(w);
    endtask

    task automatic count_rinc(input int cycles, output int n);
        n = 0;
        repeat (cycles) begin
            @(negedge rclk);
            if (rinc) n++;
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(negedge rclk);
            #1;
            k++;
        end
        chk({name, "_drain_timeout"}, (exp_q.size() == 0) ? 32'd1 : 32'd0, 32'd1);
        @(negedge rclk);
        chk({name, "_occ_after_drain"}, 32'(occ), 32'd0);
    endtask

    // scoreboard monitor
    always @(negedge rclk) begin
        if (rrst_n && m_valid && m_ready) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL stream_unexpected: got %0h expected none at %0t", m_data, $time);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (m_data !== e) begin
                    bad++;
                    $display("FAIL stream_data: got %0h expected %0h at %0t", m_data, e, $time);
                end
            end
        end
    end

    initial begin
        int n;
        logic [4:0] rinc_bits;
        total  = 0;
        bad    = 0;
        wr_ptr = 0;
        rd_ptr = 0;
        rrst_n = 1'b0;
        rd_en  = 1'b1;
        m_ready = 1'b1;

        // reset with data available and drain enabled
        push_word(8'h11);
        push_word(8'h22);
        push_word(8'h33);
        @(negedge rclk);
        @(negedge rclk);
        chk("rst_rinc", 32'(rinc), 32'd0);
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_occ", 32'(occ), 32'd0);
        chk("rst_cnt", 32'(rd_cnt), 32'd0);
        chk("rst_data", 32'(m_data), 32'd0);

        // streaming: 1-cycle latency, 1 word/cycle
        drive_edge();
        rrst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge rclk);
            rinc_bits[i] = rinc;
            if (i == 1) chk("stream_d0", 32'(m_data), 32'h11);
            if (i == 2) chk("stream_d1", 32'(m_data), 32'h22);
            if (i == 3) chk("stream_d2", 32'(m_data), 32'h33);
        end
        chk("stream_rinc_pattern", 32'(rinc_bits), 32'h07);
        chk("stream_cnt", 32'(rd_cnt), 32'd3);
        chk("stream_occ", 32'(occ), 32'd0);

        // backpressure: two pops fill the buffer, head holds
        drive_edge();
        m_ready = 1'b0;
        push_word(8'h11);
        push_word(8'h22);
        push_word(8'h33);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge rclk);
            if (rinc) n++;
            if (i >= 1) begin
                chk("bp_valid", 32'(m_valid), 32'd1);
                chk("bp_data_stable", 32'(m_data), 32'h11);
            end
        end
        chk("bp_rinc_count", 32'(n), 32'd2);
        chk("bp_occ", 32'(occ), 32'd2);
        chk("bp_rinc_low", 32'(rinc), 32'd0);
        drive_edge();
        m_ready = 1'b1;
        wait_drain("bp", 20);
        chk("bp_cnt", 32'(rd_cnt), 32'd6);

        // pause: rd_en drops after the first pop
        drive_edge();
        push_word(8'hA1);
        push_word(8'hA2);
        @(negedge rclk);
        chk("pause_rinc_first", 32'(rinc), 32'd1);
        drive_edge();
        rd_en = 1'b0;
        @(negedge rclk);
        chk("pause_rinc_drop", 32'(rinc), 32'd0);
        chk("pause_valid", 32'(m_valid), 32'd1);
        chk("pause_data", 32'(m_data), 32'hA1);
        count_rinc(3, n);
        chk("pause_no_rinc", 32'(n), 32'd0);
        chk("pause_occ", 32'(occ), 32'd0);
        drive_edge();
        rd_en = 1'b1;
        @(negedge rclk);
        chk("pause_resume", 32'(rinc), 32'd1);
        wait_drain("pause", 20);
        chk("pause_cnt", 32'(rd_cnt), 32'd8);

        // mid-burst reset at occ=2
        drive_edge();
        m_ready = 1'b0;
        push_word(8'h77);
        push_word(8'h88);
        push_word(8'h99);
        repeat (3) @(negedge rclk);
        chk("mrst_occ_full", 32'(occ), 32'd2);
        chk("mrst_head", 32'(m_data), 32'h77);
        drive_edge();
        rrst_n = 1'b0;
        #1;
        chk("mrst_occ", 32'(occ), 32'd0);
        chk("mrst_valid", 32'(m_valid), 32'd0);
        chk("mrst_rinc", 32'(rinc), 32'd0);
        chk("mrst_cnt", 32'(rd_cnt), 32'd0);
        void'(exp_q.pop_front());
        void'(exp_q.pop_front());
        drive_edge();
        rrst_n = 1'b1;
        m_ready = 1'b1;
        @(negedge rclk);
        chk("mrst_restart_rinc", 32'(rinc), 32'd1);
        wait_drain("mrst", 20);
        chk("mrst_cnt_after", 32'(rd_cnt), 32'd1);

        // wrap: bring rd_cnt to FFFF, then one more pop
        n = 0;
        while (n < 65534) begin
            drive_edge();
            if ((wr_ptr - rd_ptr) < 4) begin
                push_word(8'(n));
                n++;
            end
        end
        wait_drain("wrap_fill", 50);
        chk("wrap_cnt_max", 32'(rd_cnt), 32'hFFFF);
        drive_edge();
        push_word(8'h5A);
        wait_drain("wrap_last", 20);
        chk("wrap_cnt_zero", 32'(rd_cnt), 32'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
